// File: rtl/wb_defs.sv
// ============================================================================
// wb_defs: shared encodings for the writeback path (load sizes, slot indices).
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_defs;

    localparam logic [1:0] LD_WORD = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_BYTE = 2'b10;

    localparam int SRC_ALUFLAG = 1;
    localparam int SRC_SHIFT   = 2;
    localparam int SRC_HI      = 3;
    localparam int SRC_LO      = 5;
    localparam int SRC_MDR     = 6;
    localparam int SRC_ALUOUT  = 7;

endpackage

`default_nettype wire

// File: rtl/load_extract.sv
// ============================================================================
// load_extract: little-endian byte/halfword extraction with sign/zero extend.
// Rev 1.0
// ============================================================================
`default_nettype none

module load_extract
    import wb_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] raw_i,
    input  logic [1:0]        size_i,
    input  logic              uns_i,
    input  logic [OFF_W-1:0]  off_i,
    output logic [DATA_W-1:0] ext_o
);

    logic [OFF_W-1:0]  w_half_off;
    logic [DATA_W-1:0] w_byte_sh;
    logic [DATA_W-1:0] w_half_sh;

    // Low offset bit is dropped for halfwords: misaligned halves read the aligned lane.
    assign w_half_off = off_i & ~OFF_W'(1);
    assign w_byte_sh  = raw_i >> {off_i, 3'b000};
    assign w_half_sh  = raw_i >> {w_half_off, 3'b000};

    always_comb begin
        ext_o = raw_i;
        case (size_i)
            LD_BYTE: ext_o = {{(DATA_W-8){~uns_i & w_byte_sh[7]}}, w_byte_sh[7:0]};
            LD_HALF: ext_o = {{(DATA_W-16){~uns_i & w_half_sh[15]}}, w_half_sh[15:0]};
            default: ext_o = raw_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mux_wb_pipe.sv
// ============================================================================
// mux_wb_pipe: two-stage registered writeback source selector with flush,
// sub-word load extraction and a sticky illegal-select flag.
// Rev 1.0
// ============================================================================
`default_nettype none

module mux_wb_pipe
    import wb_defs::*;
#(
    parameter int DATA_W   = 32,
    parameter int N_SRC    = 9,
    parameter int SEL_W    = $clog2(N_SRC),
    parameter int FLAG_SRC = SRC_ALUFLAG,
    parameter int MDR_SRC  = SRC_MDR,
    parameter int OFF_W    = $clog2(DATA_W / 8)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic [1:0]              ld_size,
    input  logic                    ld_unsigned,
    input  logic [OFF_W-1:0]        byte_off,
    input  logic                    req,
    input  logic                    flush,
    output logic [DATA_W-1:0]       wb_data,
    output logic                    wb_valid,
    output logic                    sel_err
);

    logic [DATA_W-1:0] w_raw;
    logic [DATA_W-1:0] w_ext;
    logic              w_accept;
    logic              w_sel_ok;
    logic              w_issue;

    logic              s1_v_q,    s1_v_d;
    logic [DATA_W-1:0] s1_raw_q,  s1_raw_d;
    logic [1:0]        s1_size_q, s1_size_d;
    logic              s1_uns_q,  s1_uns_d;
    logic [OFF_W-1:0]  s1_off_q,  s1_off_d;
    logic              s1_ext_q,  s1_ext_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              wb_valid_q, wb_valid_d;
    logic              sel_err_q, sel_err_d;

    // Out-of-range selects match no slot and so read as zero.
    always_comb begin
        w_raw = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if ({1'b0, sel} == (SEL_W+1)'(k)) begin
                w_raw = src_data[k*DATA_W +: DATA_W];
            end
        end
        if ({1'b0, sel} == (SEL_W+1)'(FLAG_SRC)) begin
            w_raw = {{(DATA_W-1){1'b0}}, src_data[FLAG_SRC*DATA_W]};
        end
    end

    assign w_sel_ok = ({1'b0, sel} < (SEL_W+1)'(N_SRC));
    assign w_accept = req & ~flush;
    assign w_issue  = s1_v_q & ~flush;

    load_extract #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_load_extract (
        .raw_i  (s1_raw_q),
        .size_i (s1_ext_q ? s1_size_q : LD_WORD),
        .uns_i  (s1_uns_q),
        .off_i  (s1_off_q),
        .ext_o  (w_ext)
    );

    always_comb begin
        s1_v_d     = w_accept;
        s1_raw_d   = s1_raw_q;
        s1_size_d  = s1_size_q;
        s1_uns_d   = s1_uns_q;
        s1_off_d   = s1_off_q;
        s1_ext_d   = s1_ext_q;
        if (w_accept) begin
            s1_raw_d  = w_raw;
            s1_size_d = ld_size;
            s1_uns_d  = ld_unsigned;
            s1_off_d  = byte_off;
            s1_ext_d  = ({1'b0, sel} == (SEL_W+1)'(MDR_SRC));
        end
        wb_valid_d = w_issue;
        wb_data_d  = w_issue ? w_ext : wb_data_q;
        sel_err_d  = sel_err_q | (w_accept & ~w_sel_ok);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_v_q     <= 1'b0;
            s1_raw_q   <= '0;
            s1_size_q  <= LD_WORD;
            s1_uns_q   <= 1'b0;
            s1_off_q   <= '0;
            s1_ext_q   <= 1'b0;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_raw_q   <= s1_raw_d;
            s1_size_q  <= s1_size_d;
            s1_uns_q   <= s1_uns_d;
            s1_off_q   <= s1_off_d;
            s1_ext_q   <= s1_ext_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= wb_valid_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign wb_data  = wb_data_q;
    assign wb_valid = wb_valid_q;
    assign sel_err  = sel_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_wb_pipe.sv
// ============================================================================
// tb_mux_wb_pipe: scoreboard bench for mux_wb_pipe (directed + random).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux_wb_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] src [9];
    logic [287:0] src_data;
    logic [3:0]  sel = '0;
    logic [1:0]  ld_size = '0;
    logic        ld_unsigned = 1'b0;
    logic [1:0]  byte_off = '0;
    logic        req = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] wb_data;
    logic        wb_valid;
    logic        sel_err;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] scb [$];
    logic [31:0] exp_last = '0;
    bit          exp_err = 1'b0;
    bit          mon_en = 1'b0;
    bit          cand_v = 1'b0;
    logic [31:0] cand_val = '0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 9; k++) src_data[k*32 +: 32] = src[k];
    end

    mux_wb_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .src_data    (src_data),
        .sel         (sel),
        .ld_size     (ld_size),
        .ld_unsigned (ld_unsigned),
        .byte_off    (byte_off),
        .req         (req),
        .flush       (flush),
        .wb_data     (wb_data),
        .wb_valid    (wb_valid),
        .sel_err     (sel_err)
    );

    // Reference: value the register file should receive for a request.
    function automatic logic [31:0] model(int s, int sz, bit u, int o);
        logic [31:0] v;
        logic [31:0] r;
        if (s >= 9) return 32'h0;
        v = src[s];
        if (s == 1) return {31'b0, v[0]};
        if (s != 6) return v;
        if (sz == 2) begin
            r = (v >> (8 * o)) & 32'hFF;
            if (!u && r[7]) r = r | 32'hFFFFFF00;
        end else if (sz == 1) begin
            r = (v >> (16 * (o / 2))) & 32'hFFFF;
            if (!u && r[15]) r = r | 32'hFFFF0000;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // One cycle of stimulus. A request survives only if neither its capture
    // edge nor the following edge sees flush or reset.
    task automatic drive(input bit r, input int s, input int sz, input bit u,
                         input int o, input bit f, input bit rn);
        req         = r;
        sel         = 4'(s);
        ld_size     = 2'(sz);
        ld_unsigned = u;
        byte_off    = 2'(o);
        flush       = f;
        reset       = rn;
        if (cand_v && !f && rn) scb.push_back(cand_val);
        cand_v   = r && !f && rn;
        cand_val = model(s, sz, u, o);
        @(posedge clk);
        #1;
        if (!rn) begin
            exp_err  = 1'b0;
            exp_last = 32'h0;
            scb.delete();
        end else if (r && !f && s >= 9) begin
            exp_err = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic rq(input int s, input int sz, input bit u, input int o);
        drive(1, s, sz, u, o, 0, 1);
    endtask

    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                n_vec++;
                if (wb_valid) begin
                    if (scb.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_valid: wb_data=%h with nothing pending", wb_data);
                    end else begin
                        e = scb.pop_front();
                        exp_last = e;
                        if (wb_data !== e) begin
                            n_bad++;
                            $display("FAIL wb_data: got %h expected %h", wb_data, e);
                        end
                    end
                end else if (wb_data !== exp_last) begin
                    n_bad++;
                    $display("FAIL wb_hold: got %h expected %h", wb_data, exp_last);
                end
                n_vec++;
                if (sel_err !== exp_err) begin
                    n_bad++;
                    $display("FAIL sel_err: got %b expected %b", sel_err, exp_err);
                end
            end
        end
    end

    initial begin : stim
        for (int k = 0; k < 9; k++) src[k] = 32'h0;
        drive(0, 0, 0, 0, 0, 0, 0);
        mon_en = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);

        // Basic word select and latency
        src[7] = 32'hDEADBEEF;
        rq(7, 0, 0, 0);
        idle(3);

        // Sub-word loads from the memory data slot
        src[6] = 32'h80FF7F01;
        for (int o = 0; o < 4; o++) rq(6, 2, 0, o);
        for (int o = 0; o < 4; o++) rq(6, 2, 1, o);
        rq(6, 1, 0, 2);
        rq(6, 1, 0, 3);
        rq(6, 1, 1, 0);
        rq(6, 3, 0, 1);
        idle(3);

        // Flag slot and non-extracting slot ignoring ld_size
        src[1] = 32'hFFFFFFFE;
        rq(1, 0, 0, 0);
        src[1] = 32'h00000003;
        rq(1, 0, 0, 0);
        rq(7, 2, 0, 1);
        idle(3);

        // Back-to-back
        src[2] = 32'h22222222; src[3] = 32'h33333333; src[5] = 32'h55555555;
        rq(2, 0, 0, 0); rq(3, 0, 0, 0); rq(5, 0, 0, 0); rq(7, 0, 0, 0);
        idle(3);

        // Flush in stage 2, flush with req, then a normal request
        rq(3, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1);
        idle(2);
        drive(1, 5, 0, 0, 0, 1, 1);
        idle(2);
        rq(2, 0, 0, 0);
        idle(3);

        // Illegal select, sticky error, reset after a request
        rq(9, 0, 0, 0);
        idle(2);
        rq(7, 0, 0, 0);
        rq(15, 0, 0, 0);
        idle(3);
        rq(5, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        idle(4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 9; k++) src[k] = $urandom;
            drive(($urandom_range(0, 9) < 7), $urandom_range(0, 15), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) != 0));
        end

        idle(2);
        for (int i = 0; i < 20 && scb.size() != 0; i++) idle(1);
        n_vec++;
        if (scb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results outstanding, expected 0", scb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
